simple_apb_master: RTL and testbench

- APB requester that turns single-beat commands from a valid/ready request port into APB transfers (SETUP then ACCESS).
- Returns the read data and the error status on a valid/ready response port.
- It drives APB peripherals such as the timer slave on the bridge-side fabric.
- Only one transfer is outstanding at a time; no pipelining across transfers.

---
 rtl/simple_apb_master.sv | 155 +++++++++++++++
 tb/tb_simple_apb_master.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on APB, valid/ready response out.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module simple_apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]            req_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [3:0]            pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    if ((DATA_WIDTH != 32) || (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_params
        $error("simple_apb_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES in 1..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_n;
    logic                  req_ready_n, psel_n, penable_n, pwrite_n;
    logic                  rsp_valid_n, rsp_err_n;
    logic [ADDR_WIDTH-1:0] paddr_n;
    logic [DATA_WIDTH-1:0] pwdata_n, rsp_rdata_n;
    logic [3:0]            pstrb_n;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_cnt_q;

    // Counts ACCESS cycles that ended with pready low; zeroed on the way into ACCESS.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= 8'd0;
        end else if (state_q == ACCESS && !pready) begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
        end
    end
`endif

    always_comb begin
        state_n     = state_q;
        req_ready_n = req_ready;
        psel_n      = psel;
        penable_n   = penable;
        pwrite_n    = pwrite;
        paddr_n     = paddr;
        pwdata_n    = pwdata;
        pstrb_n     = pstrb;
        rsp_valid_n = rsp_valid;
        rsp_err_n   = rsp_err;
        rsp_rdata_n = rsp_rdata;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // APB transfers are word aligned; the byte offset is discarded.
                    paddr_n     = req_addr & ~ADDR_WIDTH'(3);
                    pwrite_n    = req_write;
                    pwdata_n    = req_wdata;
                    pstrb_n     = req_write ? req_strb : 4'b0000;
                    psel_n      = 1'b1;
                    penable_n   = 1'b0;
                    req_ready_n = 1'b0;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_n = pwrite ? '0 : prdata;
                    rsp_err_n   = pslverr;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    rsp_rdata_n = DATA_WIDTH'(32'hDEADBEEF);
                    rsp_err_n   = 1'b1;
                    psel_n      = 1'b0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    state_n     = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                psel_n      = 1'b0;
                penable_n   = 1'b0;
                rsp_valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            pstrb     <= 4'b0000;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state_q   <= state_n;
            req_ready <= req_ready_n;
            psel      <= psel_n;
            penable   <= penable_n;
            pwrite    <= pwrite_n;
            paddr     <= paddr_n;
            pwdata    <= pwdata_n;
            pstrb     <= pstrb_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_rdata <= rsp_rdata_n;
        end
    end

endmodule

// File: tb/tb_simple_apb_master.sv
// Directed bench for simple_apb_master; the slave side is driven by hand in each scenario task.
module tb_simple_apb_master;

    logic        pclk;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    simple_apb_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk     (pclk),
        .preset   (preset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_strb (req_strb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        preset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = 4'h0; rsp_ready = 1'b1; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        tick(); tick();
        total++;
        if ({req_ready, psel, penable, pwrite, rsp_valid, rsp_err} !== 6'b100000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=100000", {req_ready, psel, penable, pwrite, rsp_valid, rsp_err});
        end
        total++;
        if ({paddr, pwdata, pstrb, rsp_rdata} !== 100'd0) begin
            bad++; $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%h rdata=%h want all 0", paddr, pwdata, pstrb, rsp_rdata);
        end
        preset = 1'b0;
        tick();
        total++;
        if ({req_ready, psel} !== 2'b10) begin
            bad++; $display("FAIL reset_release got=%b want=10", {req_ready, psel});
        end
    endtask

    task automatic test_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h08; req_wdata = 32'h0000_1234; req_strb = 4'hF;
        pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        total++;
        if ({psel, penable, pwrite, req_ready, rsp_valid} !== 5'b10100) begin
            bad++; $display("FAIL wr_setup_ctrl got=%b want=10100", {psel, penable, pwrite, req_ready, rsp_valid});
        end
        total++;
        if (paddr !== 32'h08 || pwdata !== 32'h1234 || pstrb !== 4'hF) begin
            bad++; $display("FAIL wr_setup_bus paddr=%h pwdata=%h pstrb=%h want 8 1234 f", paddr, pwdata, pstrb);
        end
        tick();
        total++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            bad++; $display("FAIL wr_access got=%b want=110", {psel, penable, rsp_valid});
        end
        tick();
        total++;
        if ({rsp_valid, rsp_err, psel, penable} !== 4'b1000 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL wr_rsp vld_err_sel_en=%b rdata=%h want 1000 0", {rsp_valid, rsp_err, psel, penable}, rsp_rdata);
        end
        tick();
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL wr_handshake got=%b want=01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_read_wait();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h06; req_wdata = 32'hFFFF_FFFF; req_strb = 4'hF;
        pready = 1'b0; prdata = 32'h1111_1111;
        tick();
        req_valid = 1'b0;
        total++;
        if (paddr !== 32'h04 || pstrb !== 4'h0 || pwrite !== 1'b0) begin
            bad++; $display("FAIL rd_setup paddr=%h pstrb=%h pwrite=%b want 4 0 0", paddr, pstrb, pwrite);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({psel, penable, rsp_valid} !== 3'b110 || paddr !== 32'h04) begin
                bad++; $display("FAIL rd_wait%0d sel_en_vld=%b paddr=%h want 110 4", i, {psel, penable, rsp_valid}, paddr);
            end
        end
        pready = 1'b1; prdata = 32'hCAFE_0001;
        tick();
        prdata = 32'h0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0001 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL rd_rsp vld=%b rdata=%h err=%b want 1 cafe0001 0", rsp_valid, rsp_rdata, rsp_err);
        end
        tick();
    endtask

    task automatic test_slverr();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'h55; req_strb = 4'h3;
        pready = 1'b1; pslverr = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        total++;
        if ({rsp_valid, rsp_err} !== 2'b11) begin
            bad++; $display("FAIL slverr_rsp got=%b want=11", {rsp_valid, rsp_err});
        end
        pslverr = 1'b0;
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14; prdata = 32'h0000_A5A5;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_A5A5) begin
            bad++; $display("FAIL slverr_next vld=%b err=%b rdata=%h want 1 0 a5a5", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0; pready = 1'b1; pslverr = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; prdata = 32'h1357_9BDF;
        tick();
        req_write = 1'b1; req_addr = 32'h24; req_wdata = 32'h2468; req_strb = 4'h1;
        tick(); tick();
        prdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({rsp_valid, rsp_err, req_ready, psel} !== 4'b1000 || rsp_rdata !== 32'h1357_9BDF) begin
                bad++; $display("FAIL bp_hold%0d vld_err_rdy_sel=%b rdata=%h want 1000 13579bdf", i, {rsp_valid, rsp_err, req_ready, psel}, rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        total++;
        if ({rsp_valid, psel} !== 2'b10) begin
            bad++; $display("FAIL bp_prehs got=%b want=10", {rsp_valid, psel});
        end
        tick();
        total++;
        if ({rsp_valid, req_ready, psel} !== 3'b010) begin
            bad++; $display("FAIL bp_handshake got=%b want=010", {rsp_valid, req_ready, psel});
        end
        tick();
        req_valid = 1'b0;
        total++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== 32'h24 || pstrb !== 4'h1) begin
            bad++; $display("FAIL bp_second sel_en_wr=%b paddr=%h pstrb=%h want 101 24 1", {psel, penable, pwrite}, paddr, pstrb);
        end
        tick(); tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL bp_second_rsp vld=%b rdata=%h err=%b want 1 0 0", rsp_valid, rsp_rdata, rsp_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        pready = 1'b0; prdata = 32'h7777_0000;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h30;
        tick();
        req_valid = 1'b0;
        tick();
`ifdef APB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                bad++; $display("FAIL tmo_wait%0d got=%b want=110", i, {psel, penable, rsp_valid});
            end
        end
        tick();
        total++;
        if ({rsp_valid, rsp_err, psel, penable} !== 4'b1100 || rsp_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL tmo_abort vld_err_sel_en=%b rdata=%h want 1100 deadbeef", {rsp_valid, rsp_err, psel, penable}, rsp_rdata);
        end
        tick();
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++; $display("FAIL tmo_handshake got=%b want=01", {rsp_valid, req_ready});
        end
        pready = 1'b1;
`else
        repeat (100) tick();
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b1100) begin
            bad++; $display("FAIL notmo_stuck got=%b want=1100", {psel, penable, rsp_valid, req_ready});
        end
        pready = 1'b1;
        tick();
        total++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h7777_0000) begin
            bad++; $display("FAIL notmo_late vld=%b err=%b rdata=%h want 1 0 77770000", rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid_access();
        pready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hABCD; req_strb = 4'hF;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        total++;
        if ({psel, penable} !== 2'b11) begin
            bad++; $display("FAIL rst_pre got=%b want=11", {psel, penable});
        end
        #2;
        preset = 1'b1;
        #1;
        total++;
        if ({psel, penable, rsp_valid, req_ready} !== 4'b0001 || paddr !== 32'h0) begin
            bad++; $display("FAIL rst_async sel_en_vld_rdy=%b paddr=%h want 0001 0", {psel, penable, rsp_valid, req_ready}, paddr);
        end
        pready = 1'b1;
        tick();
        preset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if ({rsp_valid, psel, req_ready} !== 3'b001) begin
                bad++; $display("FAIL rst_norsp%0d got=%b want=001", i, {rsp_valid, psel, req_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_backpressure();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
